usb_slave_fifo_emu: RTL and testbench

Synthesizable emulator of the USB bridge chip's slave-FIFO side, the responder end of the interface driven by our `usb` master block. It presents FLAGB/FLAGC, serves 4-word command packets on the OUT endpoint (EP2) and captures IN endpoint (EP6) writes with PKTEND packet framing. It replaces the physical chip in loopback self-test builds and in simulation, with a host-side command-inject port and an IN-data drain port.

---
 rtl/usb_pkg.sv | 14 +
 rtl/usb_ep_fifo.sv | 64 ++++++
 rtl/usb_slave_fifo_emu.sv | 200 ++++++++++++++++++++
 tb/tb_usb_slave_fifo_emu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB slave-FIFO emulator.
package usb_pkg;

  localparam logic [1:0] EP_OUT_ADDR = 2'b00;
  localparam logic [1:0] EP_IN_ADDR  = 2'b10;
  localparam int         CMD_WORDS   = 4;
  localparam int         RSP_WORDS   = 3;

  typedef enum logic {
    OUT_EMPTY  = 1'b0,
    OUT_LOADED = 1'b1
  } out_state_e;

endpackage

// File: rtl/usb_ep_fifo.sv
// IN endpoint buffer: 17-bit entries (data + last) split into committed and uncommitted regions.
module usb_ep_fifo #(
  parameter int DEPTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr,
  input  logic [15:0]            i_wr_data,
  input  logic                   i_commit,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_valid,
  output logic [15:0]            o_data,
  output logic                   o_last,
  output logic [$clog2(DEPTH):0] o_ucnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] prev_ptr;
  logic [CW-1:0] ccnt;
  logic [CW-1:0] ucnt;
  logic [CW-1:0] ccnt_add;

  assign prev_ptr = wr_ptr - AW'(1);

  always_comb begin
    ccnt_add = '0;
    if (i_commit) ccnt_add = ucnt + CW'(i_wr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ccnt   <= '0;
      ucnt   <= '0;
    end else begin
      if (i_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (i_pop) rd_ptr <= rd_ptr + AW'(1);
      ucnt <= i_commit ? '0 : ucnt + CW'(i_wr);
      ccnt <= ccnt + ccnt_add - CW'(i_pop);
    end
  end

  // A commit without a write in the same cycle tags the previously stored word as last.
  always_ff @(posedge i_clk) begin
    if (i_wr)
      mem[wr_ptr] <= {i_commit, i_wr_data};
    else if (i_commit)
      mem[prev_ptr][16] <= 1'b1;
  end

  assign o_full  = (ccnt + ucnt) >= CW'(DEPTH);
  assign o_valid = ccnt != '0;
  assign o_data  = mem[rd_ptr][15:0];
  assign o_last  = mem[rd_ptr][16];
  assign o_ucnt  = ucnt;

endmodule

// File: rtl/usb_slave_fifo_emu.sv
// Slave-FIFO side of the USB bridge: EP2 command packets out, EP6 packets in.
// Define USB_EMU_RSP_DECODE_EN to enable the response snoop/decoder on EP6 packets.
module usb_slave_fifo_emu
  import usb_pkg::*;
#(
  parameter int IN_DEPTH  = 512,
  parameter int PKT_WORDS = 256
) (
  input  logic        i_clk_usb,
  input  logic        i_rst,
  input  logic        i_slcs,
  input  logic [1:0]  i_addr,
  input  logic        i_sloe,
  input  logic        i_slrd,
  input  logic        i_slwr,
  input  logic        i_slpked,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic        o_data_oe,
  output logic        o_flagb,
  output logic        o_flagc,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd,
  input  logic [31:0] i_cmd_param,
  output logic        o_in_valid,
  input  logic        i_in_ready,
  output logic [15:0] o_in_data,
  output logic        o_in_last,
  output logic        o_rsp_valid,
  output logic        o_rsp_err,
  output logic [15:0] o_rsp_cmd,
  output logic [15:0] o_rsp_code,
  output logic        o_ovf,
  output logic        o_udf
);

  localparam int CW = $clog2(IN_DEPTH) + 1;

  out_state_e    state_q;
  out_state_e    state_n;
  logic [15:0]   cmd_words [CMD_WORDS];
  logic [1:0]    rd_idx;
  logic          ep2_sel, ep6_sel, ep2_rd, ep6_wr, cmd_accept;
  logic          pked_q, pktend, auto_commit;
  logic          in_stored, in_commit, in_pop, in_full;
  logic          fifo_valid, fifo_last;
  logic [15:0]   fifo_data;
  logic [CW-1:0] in_ucnt;

  assign ep2_sel    = !i_slcs && (i_addr == EP_OUT_ADDR);
  assign ep6_sel    = !i_slcs && (i_addr == EP_IN_ADDR);
  assign ep2_rd     = ep2_sel && !i_slrd;
  assign ep6_wr     = ep6_sel && !i_slwr;
  assign cmd_accept = i_cmd_valid && o_cmd_ready;

  always_ff @(posedge i_clk_usb) begin
    if (i_rst) state_q <= OUT_EMPTY;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      OUT_EMPTY:  if (cmd_accept) state_n = OUT_LOADED;
      OUT_LOADED: if (ep2_rd && rd_idx == 2'(CMD_WORDS - 1)) state_n = OUT_EMPTY;
      default:    state_n = OUT_EMPTY;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_flagc     = 1'b0;
    case (state_q)
      OUT_EMPTY:  o_cmd_ready = 1'b1;
      OUT_LOADED: o_flagc     = 1'b1;
      default:    o_cmd_ready = 1'b0;
    endcase
  end

  // rd_idx wraps to 0 on the last read, which is also where the FSM returns to empty.
  always_ff @(posedge i_clk_usb) begin
    if (i_rst) begin
      for (int i = 0; i < CMD_WORDS; i++) cmd_words[i] <= '0;
      rd_idx <= '0;
      o_udf  <= 1'b0;
    end else begin
      if (cmd_accept) begin
        cmd_words[0] <= i_cmd;
        cmd_words[1] <= ~i_cmd;
        cmd_words[2] <= i_cmd_param[15:0];
        cmd_words[3] <= i_cmd_param[31:16];
        rd_idx       <= '0;
      end else if (ep2_rd && state_q == OUT_LOADED) begin
        rd_idx <= rd_idx + 2'd1;
      end
      if (ep2_rd && state_q == OUT_EMPTY) o_udf <= 1'b1;
    end
  end

  assign o_data    = cmd_words[rd_idx];
  assign o_data_oe = ep2_sel && !i_sloe;

  always_ff @(posedge i_clk_usb) begin
    if (i_rst) begin
      pked_q <= 1'b1;
      o_ovf  <= 1'b0;
    end else begin
      pked_q <= i_slpked;
      if (ep6_wr && in_full) o_ovf <= 1'b1;
    end
  end

  // A commit with nothing stored and nothing being written is a ZLP and is swallowed here.
  assign pktend      = ep6_sel && pked_q && !i_slpked;
  assign in_stored   = ep6_wr && !in_full;
  assign auto_commit = in_stored && (in_ucnt == CW'(PKT_WORDS - 1));
  assign in_commit   = (pktend || auto_commit) && (in_stored || in_ucnt != '0);
  assign in_pop      = fifo_valid && i_in_ready;

  usb_ep_fifo #(
    .DEPTH(IN_DEPTH)
  ) u_in_fifo (
    .i_clk     (i_clk_usb),
    .i_rst     (i_rst),
    .i_wr      (in_stored),
    .i_wr_data (i_data),
    .i_commit  (in_commit),
    .i_pop     (in_pop),
    .o_full    (in_full),
    .o_valid   (fifo_valid),
    .o_data    (fifo_data),
    .o_last    (fifo_last),
    .o_ucnt    (in_ucnt)
  );

  assign o_flagb    = !in_full;
  assign o_in_valid = fifo_valid;
  assign o_in_data  = fifo_valid ? fifo_data : 16'h0000;
  assign o_in_last  = fifo_valid && fifo_last;

`ifdef USB_EMU_RSP_DECODE_EN
  logic [2:0]  snoop_cnt, snoop_cnt_n;
  logic [15:0] w0, w1, w2, w0_n, w1_n, w2_n;

  // Count saturates at 4 so any packet longer than a response is still flagged.
  always_comb begin
    snoop_cnt_n = snoop_cnt;
    w0_n        = w0;
    w1_n        = w1;
    w2_n        = w2;
    if (in_stored) begin
      case (snoop_cnt)
        3'd0:    w0_n = i_data;
        3'd1:    w1_n = i_data;
        3'd2:    w2_n = i_data;
        default: w0_n = w0;
      endcase
      if (snoop_cnt != 3'd4) snoop_cnt_n = snoop_cnt + 3'd1;
    end
  end

  always_ff @(posedge i_clk_usb) begin
    if (i_rst) begin
      snoop_cnt   <= '0;
      w0          <= '0;
      w1          <= '0;
      w2          <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_cmd   <= '0;
      o_rsp_code  <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      w0          <= w0_n;
      w1          <= w1_n;
      w2          <= w2_n;
      if (in_commit) begin
        snoop_cnt <= '0;
        if (snoop_cnt_n == 3'(RSP_WORDS) && w0_n == ~w1_n) begin
          o_rsp_valid <= 1'b1;
          o_rsp_cmd   <= w0_n;
          o_rsp_code  <= w2_n;
        end else begin
          o_rsp_err <= 1'b1;
        end
      end else begin
        snoop_cnt <= snoop_cnt_n;
      end
    end
  end
`else
  assign o_rsp_valid = 1'b0;
  assign o_rsp_err   = 1'b0;
  assign o_rsp_cmd   = 16'h0000;
  assign o_rsp_code  = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_slave_fifo_emu.sv
// Directed self-checking bench for usb_slave_fifo_emu (default or USB_EMU_RSP_DECODE_EN build).
module tb_usb_slave_fifo_emu;

  logic        i_clk_usb = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_slcs = 1'b1;
  logic [1:0]  i_addr = 2'b00;
  logic        i_sloe = 1'b1, i_slrd = 1'b1, i_slwr = 1'b1, i_slpked = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_cmd_valid = 1'b0;
  logic [15:0] i_cmd = '0;
  logic [31:0] i_cmd_param = '0;
  logic        i_in_ready = 1'b0;
  logic [15:0] o_data, o_in_data, o_rsp_cmd, o_rsp_code;
  logic        o_data_oe, o_flagb, o_flagc, o_cmd_ready, o_in_valid, o_in_last;
  logic        o_rsp_valid, o_rsp_err, o_ovf, o_udf;

  int compared = 0;
  int mismatched = 0;

  usb_slave_fifo_emu dut (
    .i_clk_usb   (i_clk_usb),
    .i_rst       (i_rst),
    .i_slcs      (i_slcs),
    .i_addr      (i_addr),
    .i_sloe      (i_sloe),
    .i_slrd      (i_slrd),
    .i_slwr      (i_slwr),
    .i_slpked    (i_slpked),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_data_oe   (o_data_oe),
    .o_flagb     (o_flagb),
    .o_flagc     (o_flagc),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd       (i_cmd),
    .i_cmd_param (i_cmd_param),
    .o_in_valid  (o_in_valid),
    .i_in_ready  (i_in_ready),
    .o_in_data   (o_in_data),
    .o_in_last   (o_in_last),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_err   (o_rsp_err),
    .o_rsp_cmd   (o_rsp_cmd),
    .o_rsp_code  (o_rsp_code),
    .o_ovf       (o_ovf),
    .o_udf       (o_udf)
  );

  always #5 i_clk_usb = ~i_clk_usb;

  task automatic tick();
    @(posedge i_clk_usb);
    #1;
  endtask

  task automatic applyStimulus(input logic slcs, input logic [1:0] addr, input logic sloe,
                               input logic slrd, input logic slwr, input logic slpked,
                               input logic [15:0] data);
    i_slcs   = slcs;
    i_addr   = addr;
    i_sloe   = sloe;
    i_slrd   = slrd;
    i_slwr   = slwr;
    i_slpked = slpked;
    i_data   = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  logic [15:0] cmd_exp [4];
  logic [15:0] pkt_exp [3];

  initial begin
    cmd_exp[0] = 16'h0012; cmd_exp[1] = 16'hFFED; cmd_exp[2] = 16'hCCDD; cmd_exp[3] = 16'hAABB;
    pkt_exp[0] = 16'h0012; pkt_exp[1] = 16'hFFED; pkt_exp[2] = 16'h0000;

    tick(); tick();
    i_rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_flagb", o_flagb, 1);
    checkOutput("rst_flagc", o_flagc, 0);
    checkOutput("rst_cmd_ready", o_cmd_ready, 1);
    checkOutput("rst_data", o_data, 0);
    checkOutput("rst_data_oe", o_data_oe, 0);
    checkOutput("rst_in_valid", o_in_valid, 0);
    checkOutput("rst_in_last", o_in_last, 0);
    checkOutput("rst_rsp_valid", o_rsp_valid, 0);
    checkOutput("rst_rsp_err", o_rsp_err, 0);
    checkOutput("rst_ovf", o_ovf, 0);
    checkOutput("rst_udf", o_udf, 0);

    $display("[TB] command inject and EP2 reads");
    i_cmd_valid = 1'b1; i_cmd = 16'h0012; i_cmd_param = 32'hAABB_CCDD;
    tick();
    i_cmd_valid = 1'b0;
    checkOutput("inj_flagc", o_flagc, 1);
    checkOutput("inj_cmd_ready", o_cmd_ready, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rd_data%0d", k), o_data, cmd_exp[k]);
      checkOutput($sformatf("rd_oe%0d", k), o_data_oe, 1);
      checkOutput($sformatf("rd_flagc%0d", k), o_flagc, 1);
      tick();
    end
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
    #1;
    checkOutput("rd_done_flagc", o_flagc, 0);
    checkOutput("rd_done_cmd_ready", o_cmd_ready, 1);
    checkOutput("rd_done_udf", o_udf, 0);
    checkOutput("rd_done_oe", o_data_oe, 0);

    $display("[TB] EP6 three-word response packet");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, pkt_exp[k]);
      tick();
    end
    checkOutput("pre_commit_in_valid", o_in_valid, 0);
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
`ifdef USB_EMU_RSP_DECODE_EN
    checkOutput("rsp_valid", o_rsp_valid, 1);
    checkOutput("rsp_err", o_rsp_err, 0);
    checkOutput("rsp_cmd", o_rsp_cmd, 16'h0012);
    checkOutput("rsp_code", o_rsp_code, 16'h0000);
`else
    checkOutput("rsp_valid_off", o_rsp_valid, 0);
    checkOutput("rsp_cmd_off", o_rsp_cmd, 0);
`endif
    i_in_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("drain_valid%0d", k), o_in_valid, 1);
      checkOutput($sformatf("drain_data%0d", k), o_in_data, pkt_exp[k]);
      checkOutput($sformatf("drain_last%0d", k), o_in_last, (k == 2) ? 1 : 0);
      tick();
      checkOutput($sformatf("rsp_pulse_end%0d", k), o_rsp_valid, 0);
    end
    checkOutput("drain_empty", o_in_valid, 0);
    i_in_ready = 1'b0;

    $display("[TB] write with PKTEND, then ZLP");
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    tick();
    checkOutput("wpk_valid", o_in_valid, 1);
    checkOutput("wpk_data", o_in_data, 16'hBEEF);
    checkOutput("wpk_last", o_in_last, 1);
`ifdef USB_EMU_RSP_DECODE_EN
    checkOutput("wpk_rsp_err", o_rsp_err, 1);
`else
    checkOutput("wpk_rsp_err_off", o_rsp_err, 0);
`endif
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
    checkOutput("zlp_rsp_err", o_rsp_err, 0);
    checkOutput("zlp_rsp_valid", o_rsp_valid, 0);
    tick();
    checkOutput("zlp_rsp_err_late", o_rsp_err, 0);
    i_in_ready = 1'b1;
    #1;
    checkOutput("zlp_data", o_in_data, 16'hBEEF);
    checkOutput("zlp_last", o_in_last, 1);
    tick();
    checkOutput("zlp_no_word", o_in_valid, 0);
    tick();
    checkOutput("zlp_no_word2", o_in_valid, 0);
    i_in_ready = 1'b0;

    $display("[TB] EP2 read while empty");
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    tick();
    checkOutput("udf_set", o_udf, 1);
    checkOutput("udf_rd_idx", o_data, 16'h0012);
    checkOutput("udf_flagc", o_flagc, 0);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);

    $display("[TB] fill IN buffer");
    for (int i = 0; i < 512; i++) begin
      applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'(i));
      tick();
      if (i == 510) checkOutput("fill_flagb_511", o_flagb, 1);
    end
    checkOutput("fill_flagb_512", o_flagb, 0);
    checkOutput("fill_ovf_pre", o_ovf, 0);
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'hDEAD);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
    checkOutput("fill_ovf", o_ovf, 1);
    checkOutput("fill_flagb_513", o_flagb, 0);
    i_in_ready = 1'b1;
    #1;
    for (int i = 0; i < 512; i++) begin
      if (i == 1) checkOutput("drain_flagb_rise", o_flagb, 1);
      checkOutput($sformatf("fill_data%0d", i), o_in_data, 16'(i));
      checkOutput($sformatf("fill_last%0d", i), o_in_last, (i == 255 || i == 511) ? 1 : 0);
      tick();
    end
    checkOutput("fill_drained", o_in_valid, 0);
    i_in_ready = 1'b0;

    $display("[TB] reset mid-transfer");
    i_cmd_valid = 1'b1; i_cmd = 16'h0034; i_cmd_param = 32'h0;
    tick();
    i_cmd_valid = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'(16'h100 + i));
      tick();
    end
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
    checkOutput("mid_flagc", o_flagc, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_in_ready = 1'b1;
    #1;
    checkOutput("mid_rst_flagc", o_flagc, 0);
    checkOutput("mid_rst_cmd_ready", o_cmd_ready, 1);
    checkOutput("mid_rst_flagb", o_flagb, 1);
    checkOutput("mid_rst_in_valid", o_in_valid, 0);
    checkOutput("mid_rst_ovf", o_ovf, 0);
    checkOutput("mid_rst_udf", o_udf, 0);
    tick(); tick();
    checkOutput("mid_rst_no_drain", o_in_valid, 0);
    checkOutput("mid_rst_no_last", o_in_last, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
